// File: rtl/cb_branch_fifo.sv
// Buffered N_OUT-way branch stage: tokens queue in a DEPTH-entry FIFO and the head
// is steered to one output, broadcast to all at each channel's own pace, or dropped.
module cb_branch_fifo #(
    parameter int W     = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2,
    parameter int DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         MR_N,
    input  logic                         Send_in,
    input  logic [W-1:0]                 Data_in,
    input  logic [SEL_W-1:0]             Sel_in,
    input  logic                         Bcast_in,
    output logic                         Ack_out,
    output logic [N_OUT-1:0]             Send_out,
    output logic [W-1:0]                 Data_out,
    input  logic [N_OUT-1:0]             Ack_in,
    output logic                         CP,
    output logic                         ERR,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     data_mem  [DEPTH];
    logic [SEL_W-1:0] sel_mem   [DEPTH];
    logic             bcast_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [N_OUT-1:0] done_reg, done_next;
    logic             cp_reg, err_reg;

    logic             not_empty, full, push, pop;
    logic [W-1:0]     head_data;
    logic [SEL_W-1:0] head_sel;
    logic             head_bcast;
    logic [N_OUT-1:0] head_mask, fire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_data  = data_mem[rd_ptr_reg];
    assign head_sel   = sel_mem[rd_ptr_reg];
    assign head_bcast = bcast_mem[rd_ptr_reg];

    // An out-of-range select matches no channel, so the mask is simply zero.
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_mask
        assign head_mask[gi] = head_bcast | (head_sel == SEL_W'(gi));
    end

    assign not_empty = (count_reg != '0);
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign Ack_out   = MR_N & ~full;
    assign push      = Send_in & Ack_out;

    assign Send_out  = {N_OUT{MR_N & not_empty}} & head_mask & ~done_reg;
    assign fire      = Send_out & Ack_in;
    assign pop       = not_empty & ((head_mask & ~(done_reg | fire)) == '0);
    assign Data_out  = not_empty ? head_data : '0;

    assign CP    = cp_reg;
    assign ERR   = err_reg;
    assign Count = count_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        done_next   = done_reg | fire;
        if (push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
            done_next   = '0;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Token storage carries no reset; emptiness is tracked by count_reg alone.
    always_ff @(posedge CLK) begin
        if (push) begin
            data_mem[wr_ptr_reg]  <= Data_in;
            sel_mem[wr_ptr_reg]   <= Sel_in;
            bcast_mem[wr_ptr_reg] <= Bcast_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (!MR_N) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            done_reg   <= '0;
            cp_reg     <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            done_reg   <= done_next;
            cp_reg     <= push;
            err_reg    <= pop & (head_mask == '0);
        end
    end

endmodule

// File: tb/tb_cb_branch_fifo.sv
// Bench for cb_branch_fifo: directed table (4-way), a 3-way invalid-select sequence,
// and random traffic against a queue-based reference model.
module tb_cb_branch_fifo;

    localparam int DEPTH = 4;
    localparam int N1    = 4;

    logic       CLK = 1'b0;
    logic       MR_N;
    always #5 CLK = ~CLK;

    // 4-way instance
    logic       send, bcast, ack_out, cp, err;
    logic [7:0] data, data_out;
    logic [1:0] sel;
    logic [3:0] ack_in, send_out;
    logic [2:0] count;

    // 3-way instance
    logic       s3_send, s3_bcast, s3_ack_out, s3_cp, s3_err;
    logic [7:0] s3_data, s3_data_out;
    logic [1:0] s3_sel;
    logic [2:0] s3_ack_in, s3_send_out;
    logic [2:0] s3_count;

    cb_branch_fifo #(.W(8), .N_OUT(4), .SEL_W(2), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .MR_N(MR_N), .Send_in(send), .Data_in(data), .Sel_in(sel),
        .Bcast_in(bcast), .Ack_out(ack_out), .Send_out(send_out), .Data_out(data_out),
        .Ack_in(ack_in), .CP(cp), .ERR(err), .Count(count));

    cb_branch_fifo #(.W(8), .N_OUT(3), .SEL_W(2), .DEPTH(DEPTH)) dut3 (
        .CLK(CLK), .MR_N(MR_N), .Send_in(s3_send), .Data_in(s3_data), .Sel_in(s3_sel),
        .Bcast_in(s3_bcast), .Ack_out(s3_ack_out), .Send_out(s3_send_out),
        .Data_out(s3_data_out), .Ack_in(s3_ack_in), .CP(s3_cp), .ERR(s3_err),
        .Count(s3_count));

    typedef struct {
        logic       mr_n, send;
        logic [7:0] data;
        logic [1:0] sel;
        logic       bcast;
        logic [3:0] ack;
        logic       chk;
        logic       exp_ack;
        logic [3:0] exp_send;
        logic [7:0] exp_data;
        logic       exp_cp;
        logic [2:0] exp_count;
    } vec_t;

    typedef struct {
        logic       send;
        logic [7:0] data;
        logic [1:0] sel;
        logic [2:0] ack;
        logic       chk;
        logic [2:0] exp_send;
        logic [7:0] exp_data;
        logic       exp_err;
        logic [2:0] exp_count;
    } vec3_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] sel;
        logic       bcast;
    } tok_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    tok_t       mq[$];
    logic [3:0] m_delivered;
    logic       m_cp, m_err, m_ok;

    function automatic vec_t mk(logic mr_n, logic s, logic [7:0] d, logic [1:0] sl,
                                logic b, logic [3:0] a, logic ea, logic [3:0] es,
                                logic [7:0] ed, logic ec, logic [2:0] en);
        vec_t v;
        v.mr_n = mr_n; v.send = s; v.data = d; v.sel = sl; v.bcast = b; v.ack = a;
        v.chk = 1'b1; v.exp_ack = ea; v.exp_send = es; v.exp_data = ed;
        v.exp_cp = ec; v.exp_count = en;
        return v;
    endfunction

    function automatic vec3_t mk3(logic s, logic [7:0] d, logic [1:0] sl, logic [2:0] a,
                                  logic c, logic [2:0] es, logic [7:0] ed, logic ee,
                                  logic [2:0] en);
        vec3_t v;
        v.send = s; v.data = d; v.sel = sl; v.ack = a; v.chk = c;
        v.exp_send = es; v.exp_data = ed; v.exp_err = ee; v.exp_count = en;
        return v;
    endfunction

    function automatic logic [3:0] m_mask(tok_t t);
        if (t.bcast) return 4'hF;
        if (int'(t.sel) < N1) return 4'(1 << t.sel);
        return 4'h0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(vec_t v, vec3_t v3);
        logic [3:0] mask, exp_send, fire;
        logic       exp_ack, pop, push;
        MR_N = v.mr_n; send = v.send; data = v.data; sel = v.sel; bcast = v.bcast;
        ack_in = v.ack;
        s3_send = v3.send; s3_data = v3.data; s3_sel = v3.sel; s3_bcast = 1'b0;
        s3_ack_in = v3.ack;
        #1;
        if (v.chk) begin
            chk("tbl_ack_out", 32'(ack_out), 32'(v.exp_ack));
            chk("tbl_send_out", 32'(send_out), 32'(v.exp_send));
            chk("tbl_count", 32'(count), 32'(v.exp_count));
            chk("tbl_cp", 32'(cp), 32'(v.exp_cp));
            chk("tbl_err", 32'(err), 32'd0);
            if (v.exp_send != 4'h0) chk("tbl_data", 32'(data_out), 32'(v.exp_data));
        end
        if (v3.chk) begin
            chk("n3_send_out", 32'(s3_send_out), 32'(v3.exp_send));
            chk("n3_err", 32'(s3_err), 32'(v3.exp_err));
            chk("n3_count", 32'(s3_count), 32'(v3.exp_count));
            if (v3.exp_send != 3'h0) chk("n3_data", 32'(s3_data_out), 32'(v3.exp_data));
        end
        // Model: expected outputs this cycle, then the state change at the edge.
        mask     = (mq.size() > 0) ? m_mask(mq[0]) : 4'h0;
        exp_ack  = v.mr_n && (mq.size() < DEPTH);
        exp_send = (v.mr_n && mq.size() > 0) ? (mask & ~m_delivered) : 4'h0;
        if (m_ok) begin
            chk("mdl_ack_out", 32'(ack_out), 32'(exp_ack));
            chk("mdl_send_out", 32'(send_out), 32'(exp_send));
            chk("mdl_count", 32'(count), 32'(mq.size()));
            chk("mdl_cp", 32'(cp), 32'(m_cp));
            chk("mdl_err", 32'(err), 32'(m_err));
            if (mq.size() > 0) chk("mdl_data", 32'(data_out), 32'(mq[0].data));
        end
        if (!v.mr_n) begin
            mq.delete();
            m_delivered = 4'h0; m_cp = 1'b0; m_err = 1'b0; m_ok = 1'b1;
        end else begin
            fire = exp_send & v.ack;
            pop  = (mq.size() > 0) && ((mask & ~(m_delivered | fire)) == 4'h0);
            push = v.send && exp_ack;
            m_err = pop && (mask == 4'h0);
            m_cp  = push;
            if (pop) begin
                void'(mq.pop_front());
                m_delivered = 4'h0;
            end else begin
                m_delivered = m_delivered | fire;
            end
            if (push) mq.push_back('{data: v.data, sel: v.sel, bcast: v.bcast});
        end
        @(negedge CLK);
    endtask

    vec_t  tbl[$];
    vec3_t seq3[$];
    vec3_t idle3;
    vec_t  idle1, rv;

    initial begin
        m_ok = 1'b0; m_delivered = 4'h0; m_cp = 1'b0; m_err = 1'b0;
        idle3 = mk3(0, 8'h00, 2'd0, 3'b000, 0, 3'b000, 8'h00, 0, 3'd0);
        idle1 = mk(1, 0, 8'h00, 2'd0, 0, 4'h0, 0, 4'h0, 8'h00, 0, 3'd0);
        idle1.chk = 1'b0;

        //              mr s data  sel b ack      eack esend  edata cp cnt
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 8'hA5, 2, 0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0100, 8'hA5, 1, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 8'h01, 0, 0, 4'b0000, 1, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 8'h02, 1, 0, 4'b0000, 1, 4'b0001, 8'h01, 1, 1));
        tbl.push_back(mk(1, 1, 8'h03, 2, 0, 4'b0000, 1, 4'b0001, 8'h01, 1, 2));
        tbl.push_back(mk(1, 1, 8'h04, 3, 0, 4'b0000, 1, 4'b0001, 8'h01, 1, 3));
        tbl.push_back(mk(1, 1, 8'h05, 0, 0, 4'b0000, 0, 4'b0001, 8'h01, 1, 4));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1111, 0, 4'b0001, 8'h01, 0, 4));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0010, 8'h02, 0, 3));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0100, 8'h03, 0, 2));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b1000, 8'h04, 0, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 8'h3C, 0, 1, 4'b0000, 1, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b0001, 1, 4'b1111, 8'h3C, 1, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b0110, 1, 4'b1110, 8'h3C, 0, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1000, 1, 4'b1000, 8'h3C, 0, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b0000, 1, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 8'h10, 0, 0, 4'b0000, 1, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 8'h11, 1, 0, 4'b0000, 1, 4'b0001, 8'h10, 1, 1));
        tbl.push_back(mk(1, 1, 8'h12, 2, 0, 4'b0001, 1, 4'b0001, 8'h10, 1, 2));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b0000, 1, 4'b0010, 8'h11, 1, 2));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0010, 8'h11, 0, 2));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0100, 8'h12, 0, 1));
        tbl.push_back(mk(1, 1, 8'h3C, 0, 1, 4'b0000, 1, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b0001, 1, 4'b1111, 8'h3C, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'b0000, 0, 4'b0000, 8'h00, 0, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0));

        //                 s data   sel ack   c esend  edata err cnt
        seq3.push_back(mk3(1, 8'h77, 3, 3'b111, 1, 3'b000, 8'h00, 0, 0));
        seq3.push_back(mk3(0, 8'h00, 0, 3'b111, 1, 3'b000, 8'h00, 0, 1));
        seq3.push_back(mk3(0, 8'h00, 0, 3'b111, 1, 3'b000, 8'h00, 1, 0));
        seq3.push_back(mk3(1, 8'h5A, 1, 3'b111, 1, 3'b000, 8'h00, 0, 0));
        seq3.push_back(mk3(0, 8'h00, 0, 3'b111, 1, 3'b010, 8'h5A, 0, 1));
        seq3.push_back(mk3(0, 8'h00, 0, 3'b111, 1, 3'b000, 8'h00, 0, 0));

        // Initial reset cycle establishes a known state before any checking.
        rv = tbl[0];
        rv.chk = 1'b0;
        step(rv, idle3);

        foreach (tbl[i]) step(tbl[i], idle3);
        foreach (seq3[i]) step(idle1, seq3[i]);

        for (int i = 0; i < 600; i++) begin
            rv.mr_n  = ($urandom_range(0, 49) != 0);
            rv.send  = $urandom_range(0, 1);
            rv.data  = 8'($urandom);
            rv.sel   = 2'($urandom);
            rv.bcast = ($urandom_range(0, 3) == 0);
            rv.ack   = 4'($urandom);
            rv.chk   = 1'b0;
            step(rv, idle3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
